// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states,
// the reset value of a PHT entry and the default table/history sizes.
package bp_pkg;

  localparam int DEF_PHT_IDX_W = 5;
  localparam int DEF_GHR_W     = 5;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_state_e;

  localparam ctr_state_e CTR_RESET = CTR_WNT;

  // The predicted direction is the counter's upper bit.
  function automatic logic ctr_taken(input ctr_state_e state);
    return state[1];
  endfunction

endpackage

// File: rtl/sat_ctr2_next.sv
// Next-state function of a 2-bit saturating counter.
// The counter moves one step toward the outcome and stops at either end.
module sat_ctr2_next
  import bp_pkg::*;
(
  input  ctr_state_e state,
  input  logic       taken,
  output ctr_state_e next_state
);

  // Step one state toward the observed outcome, saturating at the ends
  always_comb begin
    next_state = state;
    case (state)
      CTR_SNT: begin
        if (taken) next_state = CTR_WNT;
        else       next_state = CTR_SNT;
      end
      CTR_WNT: begin
        if (taken) next_state = CTR_WT;
        else       next_state = CTR_SNT;
      end
      CTR_WT: begin
        if (taken) next_state = CTR_ST;
        else       next_state = CTR_WNT;
      end
      CTR_ST: begin
        if (taken) next_state = CTR_ST;
        else       next_state = CTR_WT;
      end
      default: next_state = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC bits XOR global history index a table of
// 2-bit counters; one-cycle registered prediction, non-speculative history.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PHT_IDX_W = DEF_PHT_IDX_W,
  parameter int GHR_W     = DEF_GHR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pred_req,
  input  logic [31:0]          pred_pc,
  output logic                 pred_rsp_valid,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic [31:0]          br_count,
  output logic [31:0]          mispred_count
);

  localparam int NUM_ENT = 2 ** PHT_IDX_W;

  ctr_state_e             pht_q [NUM_ENT];
  ctr_state_e             pht_d [NUM_ENT];
  logic [GHR_W-1:0]       ghr_q, ghr_d;
  logic                   pred_rsp_valid_q, pred_rsp_valid_d;
  logic                   pred_taken_q, pred_taken_d;
  logic [PHT_IDX_W-1:0]   pred_idx_q, pred_idx_d;
  logic [31:0]            br_count_q, br_count_d;
  logic [31:0]            mispred_count_q, mispred_count_d;

  logic [PHT_IDX_W-1:0]   ghr_ext_s;
  logic [PHT_IDX_W-1:0]   lookup_idx_s;
  ctr_state_e             upd_cur_s;
  ctr_state_e             upd_next_s;
  logic                   unused_pc_bits_s;

  assign unused_pc_bits_s = ^{pred_pc[31:PHT_IDX_W+2], pred_pc[1:0]};

  // Lookup index: word-aligned PC bits hashed with zero-extended history
  always_comb begin
    ghr_ext_s               = {PHT_IDX_W{1'b0}};
    ghr_ext_s[GHR_W-1:0]    = ghr_q;
    lookup_idx_s            = pred_pc[PHT_IDX_W+1:2] ^ ghr_ext_s;
    upd_cur_s               = pht_q[upd_idx];
  end

  sat_ctr2_next u_upd_ctr (
    .state      (upd_cur_s),
    .taken      (upd_taken),
    .next_state (upd_next_s)
  );

  // Prediction reads the current (pre-update) table and history
  always_comb begin
    pred_rsp_valid_d = pred_req;
    if (pred_req) begin
      pred_taken_d = ctr_taken(pht_q[lookup_idx_s]);
      pred_idx_d   = lookup_idx_s;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
    end
  end

  // Resolved branch: train the counter, shift history, bump statistics
  always_comb begin
    pht_d           = pht_q;
    ghr_d           = ghr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid) begin
      pht_d[upd_idx] = upd_next_s;
      ghr_d          = ghr_q << 1;
      ghr_d[0]       = upd_taken;
      br_count_d     = br_count_q + 32'd1;
      if (upd_mispredict) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end else begin
        mispred_count_d = mispred_count_q;
      end
    end else begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
    end
  end

  // State registers; reset also drops any response still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        pht_q[i] <= CTR_RESET;
      end
      ghr_q            <= {GHR_W{1'b0}};
      pred_rsp_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_idx_q       <= {PHT_IDX_W{1'b0}};
      br_count_q       <= 32'd0;
      mispred_count_q  <= 32'd0;
    end else begin
      pht_q            <= pht_d;
      ghr_q            <= ghr_d;
      pred_rsp_valid_q <= pred_rsp_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_idx_q       <= pred_idx_d;
      br_count_q       <= br_count_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

  assign pred_rsp_valid = pred_rsp_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_idx       = pred_idx_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: an abstract table/history model is
// compared every cycle, plus literal expectations at the key scenario points.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_rsp_valid;
  logic        pred_taken;
  logic [4:0]  pred_idx;
  logic        upd_valid = 1'b0;
  logic [4:0]  upd_idx = 5'd0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  gshare_predictor #(.PHT_IDX_W(5), .GHR_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_rsp_valid (pred_rsp_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  // Reference model: counters kept as plain integers 0..3, history as 0..31
  int          m_pht [32];
  int          m_ghr;
  logic        m_valid;
  logic        m_taken;
  int          m_idx;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  function automatic int idx_of(input logic [31:0] pc, input int ghr);
    return ((pc / 4) % 32) ^ ghr;
  endfunction

  function automatic int train(input int c, input logic t);
    if (t) return (c == 3) ? 3 : c + 1;
    else   return (c == 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_pht[i] <= 1;
      m_ghr   <= 0;
      m_valid <= 1'b0;
      m_taken <= 1'b0;
      m_idx   <= 0;
      m_br    <= 32'd0;
      m_mis   <= 32'd0;
    end else begin
      m_valid <= pred_req;
      if (pred_req) begin
        m_idx   <= idx_of(pred_pc, m_ghr);
        m_taken <= (m_pht[idx_of(pred_pc, m_ghr)] >= 2);
      end
      if (upd_valid) begin
        m_pht[upd_idx] <= train(m_pht[upd_idx], upd_taken);
        m_ghr          <= (m_ghr * 2 + int'(upd_taken)) % 32;
        m_br           <= m_br + 32'd1;
        if (upd_mispredict) m_mis <= m_mis + 32'd1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge
  always @(posedge clk) begin
    #2;
    check("model.valid", {31'd0, pred_rsp_valid}, {31'd0, m_valid});
    check("model.taken", {31'd0, pred_taken}, {31'd0, m_taken});
    check("model.idx", {27'd0, pred_idx}, m_idx);
    check("model.br_count", br_count, m_br);
    check("model.mispred_count", mispred_count, m_mis);
  end

  task automatic drive(input logic req, input logic [31:0] pc, input logic uv,
                       input logic [4:0] ui, input logic ut, input logic um);
    @(negedge clk);
    pred_req       = req;
    pred_pc        = pc;
    upd_valid      = uv;
    upd_idx        = ui;
    upd_taken      = ut;
    upd_mispredict = um;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic resp_check(input string nm, input logic et, input logic [4:0] ei);
    @(posedge clk);
    #2;
    check({nm, ".valid"}, {31'd0, pred_rsp_valid}, 32'd1);
    check({nm, ".taken"}, {31'd0, pred_taken}, {31'd0, et});
    check({nm, ".idx"}, {27'd0, pred_idx}, {27'd0, ei});
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs while held in reset
    repeat (2) @(posedge clk);
    #2;
    check("rst.valid", {31'd0, pred_rsp_valid}, 32'd0);
    check("rst.idx", {27'd0, pred_idx}, 32'd0);
    check("rst.br", br_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First prediction after reset
    drive(1'b1, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("pc0", 1'b0, 5'd0);
    idle();
    @(posedge clk);
    #2;
    check("pc0.drop", {31'd0, pred_rsp_valid}, 32'd0);
    check("pc0.hold", {27'd0, pred_idx}, 32'd0);

    // idx 3 trained taken three times, saturating at strong-taken
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0);
    drive(1'b1, 32'h08, 1'b1, 5'd3, 1'b1, 1'b0);
    resp_check("idx3.weakT", 1'b1, 5'd3);
    drive(1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0);
    drive(1'b1, 32'h10, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("idx3.strongT", 1'b1, 5'd3);

    // idx 7 from strong-taken down through four not-taken, floor at 00
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
    drive(1'b1, 32'h10, 1'b1, 5'd7, 1'b0, 1'b0);
    resp_check("idx7.st", 1'b1, 5'd7);
    drive(1'b1, 32'h04, 1'b1, 5'd7, 1'b0, 1'b0);
    resp_check("idx7.wt", 1'b1, 5'd7);
    drive(1'b1, 32'h2C, 1'b1, 5'd7, 1'b0, 1'b0);
    resp_check("idx7.wnt", 1'b0, 5'd7);
    drive(1'b1, 32'h7C, 1'b1, 5'd7, 1'b0, 1'b0);
    resp_check("idx7.snt", 1'b0, 5'd7);
    drive(1'b1, 32'h5C, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("idx7.floor", 1'b0, 5'd7);
    drive(1'b0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
    drive(1'b1, 32'h18, 1'b1, 5'd7, 1'b1, 1'b0);
    resp_check("idx7.up1", 1'b0, 5'd7);
    drive(1'b1, 32'h10, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("idx7.up2", 1'b1, 5'd7);

    // History T,NT,T = 00101 cancels pc field 5
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 5'd10, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 5'd11, 1'b1, 1'b0);
    drive(1'b1, 32'h14, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("ghr5", 1'b0, 5'd0);

    // Same-cycle predict and update on idx 0: response sees old counter
    drive(1'b1, 32'h14, 1'b1, 5'd0, 1'b1, 1'b0);
    resp_check("rbw.old", 1'b0, 5'd0);
    drive(1'b1, 32'h2C, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("rbw.new", 1'b1, 5'd0);

    // Statistics: ten resolved, three mispredicted, one ignored flag
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b1, 5'(i), i[0], (i == 1 || i == 4 || i == 7));
      if (i == 5) drive(1'b0, 32'h0, 1'b0, 5'd2, 1'b1, 1'b1);
    end
    idle();
    @(posedge clk);
    #2;
    check("stat.br", br_count, 32'd10);
    check("stat.mis", mispred_count, 32'd3);

    // Reset mid-stream with a response in flight
    drive(1'b1, 32'h40, 1'b1, 5'd4, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("mid.valid", {31'd0, pred_rsp_valid}, 32'd1);
    @(negedge clk);
    rst_n    = 1'b0;
    pred_req = 1'b0;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    #2;
    check("mid.rst.valid", {31'd0, pred_rsp_valid}, 32'd0);
    check("mid.rst.br", br_count, 32'd0);
    check("mid.rst.mis", mispred_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    resp_check("post.rst", 1'b0, 5'd0);
    idle();
    repeat (2) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
